jam_cost_server: RTL and testbench

JAM_COST_SERVER -- requirements
Module: jam_cost_server

---
 rtl/jam_pkg.sv | 21 ++
 rtl/jam_cost_table.sv | 26 ++
 rtl/jam_cost_server.sv | 113 +++++++++++
 tb/tb_jam_cost_server.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Definitions shared by the cost server and the assignment engine.
// Covers the state encoding, the table geometry and the datapath widths.
package jam_pkg;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_SERVE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_TOUT    = 3'd4
  } jam_state_t;

  localparam int N_JOBS      = 8;
  localparam int TABLE_DEPTH = 64;
  localparam int COST_W      = 7;
  localparam int SUM_W       = 10;
  localparam int IDX_W       = 6;
  localparam int CNT_W       = 16;
  localparam int MATCH_W     = 4;

endpackage

// File: rtl/jam_cost_table.sv
// Cost storage with one synchronous write port and one combinational read port.
// It has no reset: contents survive RST and are overwritten by the next load.
module jam_cost_table
  import jam_pkg::*;
#(
  parameter int DEPTH = TABLE_DEPTH,
  parameter int AW    = IDX_W,
  parameter int DW    = COST_W
) (
  input  logic          CLK,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/jam_cost_server.sv
// Loads an N_JOBS x N_JOBS cost table, holds the assignment engine in reset
// until the table is ready, serves costs to it, then captures the result or times out.
//
// state   | meaning
// LOAD    | accepting cost entries, engine held in reset
// RELEASE | one-cycle gap after the last entry, engine still in reset
// SERVE   | engine running, costs served, cycle counter running
// DONE    | result captured, terminal until RST
// TOUT    | engine did not report in time, terminal until RST
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 45000,
  parameter int N_JOBS         = jam_pkg::N_JOBS
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_valid,
  input  logic [COST_W-1:0]  load_data,
  output logic               load_ready,
  output logic               jam_rst,
  input  logic [2:0]         W,
  input  logic [2:0]         J,
  output logic [COST_W-1:0]  Cost,
  input  logic               Valid,
  input  logic [SUM_W-1:0]   MinCost,
  input  logic [MATCH_W-1:0] MatchCount,
  output logic               done,
  output logic [SUM_W-1:0]   res_min,
  output logic [MATCH_W-1:0] res_cnt,
  output logic               timeout
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_JOBS * N_JOBS - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  jam_state_t          r_state;
  jam_state_t          w_next_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic                r_tout;
  logic [SUM_W-1:0]    r_res_min;
  logic [MATCH_W-1:0]  r_res_cnt;
  logic                w_wr_en;
  logic                w_serving;
  logic [COST_W-1:0]   w_rd_data;

  jam_cost_table #(
    .DEPTH (TABLE_DEPTH),
    .AW    (IDX_W),
    .DW    (COST_W)
  ) u_table (
    .CLK       (CLK),
    .i_we      (w_wr_en),
    .i_wr_addr (r_idx),
    .i_wr_data (load_data),
    .i_rd_addr ({W, J}),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_next_state = r_state;
    w_wr_en      = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (load_valid && !RST) begin
          w_wr_en = 1'b1;
          if (r_idx == LAST_IDX) w_next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: w_next_state = ST_SERVE;
      ST_SERVE: begin
        // A result arriving on the final allowed cycle still counts.
        if (Valid)                  w_next_state = ST_DONE;
        else if (r_cnt == TO_LAST)  w_next_state = ST_TOUT;
      end
      default: w_next_state = r_state;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_LOAD;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_tout    <= 1'b0;
      r_res_min <= '0;
      r_res_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_wr_en) r_idx <= r_idx + 1'b1;
      r_cnt <= (r_state == ST_SERVE) ? r_cnt + 1'b1 : '0;
      if (r_state == ST_SERVE && Valid) begin
        r_res_min <= MinCost;
        r_res_cnt <= MatchCount;
        r_done    <= 1'b1;
      end
      if (w_next_state == ST_TOUT) r_tout <= 1'b1;
    end
  end

  assign w_serving  = (r_state == ST_SERVE) || (r_state == ST_DONE) || (r_state == ST_TOUT);
  assign load_ready = (r_state == ST_LOAD) && !RST;
  assign jam_rst    = RST || (r_state == ST_LOAD) || (r_state == ST_RELEASE);
  assign Cost       = w_serving ? w_rd_data : '0;
  assign done       = r_done;
  assign timeout    = r_tout;
  assign res_min    = r_res_min;
  assign res_cnt    = r_res_cnt;

endmodule

// File: tb/tb_jam_cost_server.sv
// Directed bench for jam_cost_server: one default instance plus one with a short timeout,
// both sharing stimulus.
module tb_jam_cost_server;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       load_valid = 1'b0;
  logic [6:0] load_data = '0;
  logic [2:0] W = '0;
  logic [2:0] J = '0;
  logic       Valid = 1'b0;
  logic [9:0] MinCost = '0;
  logic [3:0] MatchCount = '0;

  logic       a_load_ready, a_jam_rst, a_done, a_timeout;
  logic [6:0] a_cost;
  logic [9:0] a_res_min;
  logic [3:0] a_res_cnt;
  logic       b_load_ready, b_jam_rst, b_done, b_timeout;
  logic [6:0] b_cost;
  logic [9:0] b_res_min;
  logic [3:0] b_res_cnt;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_tab [64];

  jam_cost_server dut_a (
    .CLK(CLK), .RST(RST), .load_valid(load_valid), .load_data(load_data),
    .load_ready(a_load_ready), .jam_rst(a_jam_rst), .W(W), .J(J), .Cost(a_cost),
    .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount), .done(a_done),
    .res_min(a_res_min), .res_cnt(a_res_cnt), .timeout(a_timeout)
  );

  jam_cost_server #(.TIMEOUT_CYCLES(100)) dut_b (
    .CLK(CLK), .RST(RST), .load_valid(load_valid), .load_data(load_data),
    .load_ready(b_load_ready), .jam_rst(b_jam_rst), .W(W), .J(J), .Cost(b_cost),
    .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount), .done(b_done),
    .res_min(b_res_min), .res_cnt(b_res_cnt), .timeout(b_timeout)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    total++; if (a_load_ready !== 1'b0) begin bad++; $display("FAIL rst_load_ready: got %0d want 0", a_load_ready); end
    total++; if (a_jam_rst !== 1'b1) begin bad++; $display("FAIL rst_jam_rst: got %0d want 1", a_jam_rst); end
    total++; if ({a_done, a_timeout} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", {a_done, a_timeout}); end
    total++; if ({a_res_min, a_res_cnt} !== 14'd0) begin bad++; $display("FAIL rst_results: got %0d/%0d want 0/0", a_res_min, a_res_cnt); end
    total++; if (a_cost !== 7'd0) begin bad++; $display("FAIL rst_cost: got %0d want 0", a_cost); end
    RST = 1'b0;
    #1;
    total++; if (a_load_ready !== 1'b1) begin bad++; $display("FAIL load_ready_after_rst: got %0d want 1", a_load_ready); end
  endtask

  task automatic test_load_full();
    int acc = 0;
    load_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      load_data = 7'(i);
      #1;
      if (a_load_ready === 1'b1) acc++;
      tick();
    end
    load_valid = 1'b0;
    total++; if (acc != 64) begin bad++; $display("FAIL full_accepts: got %0d want 64", acc); end
    total++; if (a_load_ready !== 1'b0 || a_jam_rst !== 1'b1) begin bad++; $display("FAIL release_outputs: got ready=%0d jam_rst=%0d want 0/1", a_load_ready, a_jam_rst); end
    W = 3'd3; J = 3'd5;
    #1;
    total++; if (a_cost !== 7'd0) begin bad++; $display("FAIL release_cost: got %0d want 0", a_cost); end
    tick();
    total++; if (a_jam_rst !== 1'b0) begin bad++; $display("FAIL serve_jam_rst: got %0d want 0", a_jam_rst); end
    total++; if (a_cost !== 7'd29) begin bad++; $display("FAIL cost_w3_j5: got %0d want 29", a_cost); end
    W = 3'd7; J = 3'd7;
    #1;
    total++; if (a_cost !== 7'd63) begin bad++; $display("FAIL cost_w7_j7: got %0d want 63", a_cost); end
    W = 3'd0; J = 3'd0;
    #1;
    total++; if (a_cost !== 7'd0) begin bad++; $display("FAIL cost_w0_j0: got %0d want 0", a_cost); end
  endtask

  // Entered at SERVE counter 0; leaves both instances at SERVE cycle 100.
  task automatic test_timeout();
    repeat (99) tick();
    total++; if (b_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early: got %0d want 0", b_timeout); end
    tick();
    total++; if (b_timeout !== 1'b1) begin bad++; $display("FAIL timeout_set: got %0d want 1", b_timeout); end
    total++; if (b_done !== 1'b0) begin bad++; $display("FAIL timeout_done: got %0d want 0", b_done); end
    W = 3'd3; J = 3'd5;
    #1;
    total++; if (b_cost !== 7'd29) begin bad++; $display("FAIL timeout_cost: got %0d want 29", b_cost); end
    total++; if (b_jam_rst !== 1'b0) begin bad++; $display("FAIL timeout_jam_rst: got %0d want 0", b_jam_rst); end
    total++; if (a_timeout !== 1'b0) begin bad++; $display("FAIL long_timeout_early: got %0d want 0", a_timeout); end
  endtask

  task automatic test_valid_capture();
    repeat (40300) tick();
    total++; if (a_done !== 1'b0 || a_timeout !== 1'b0) begin bad++; $display("FAIL pre_valid_flags: got done=%0d to=%0d want 0/0", a_done, a_timeout); end
    Valid = 1'b1; MinCost = 10'd323; MatchCount = 4'd2;
    tick();
    Valid = 1'b0; MinCost = 10'd0; MatchCount = 4'd0;
    #1;
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL capture_done: got %0d want 1", a_done); end
    total++; if (a_res_min !== 10'd323) begin bad++; $display("FAIL capture_min: got %0d want 323", a_res_min); end
    total++; if (a_res_cnt !== 4'd2) begin bad++; $display("FAIL capture_cnt: got %0d want 2", a_res_cnt); end
    Valid = 1'b1; MinCost = 10'd777; MatchCount = 4'd9;
    tick();
    Valid = 1'b0;
    tick();
    total++; if (a_res_min !== 10'd323 || a_res_cnt !== 4'd2) begin bad++; $display("FAIL second_valid: got %0d/%0d want 323/2", a_res_min, a_res_cnt); end
    total++; if (a_done !== 1'b1 || a_timeout !== 1'b0) begin bad++; $display("FAIL done_hold: got done=%0d to=%0d want 1/0", a_done, a_timeout); end
    total++; if (b_done !== 1'b0 || b_res_min !== 10'd0) begin bad++; $display("FAIL tout_ignores_valid: got done=%0d min=%0d want 0/0", b_done, b_res_min); end
    total++; if (a_cost !== 7'd29) begin bad++; $display("FAIL done_cost: got %0d want 29", a_cost); end
  endtask

  task automatic test_rst_serve();
    RST = 1'b1;
    #1;
    total++; if (a_jam_rst !== 1'b1 || a_load_ready !== 1'b0) begin bad++; $display("FAIL rst_in_done: got jam_rst=%0d ready=%0d want 1/0", a_jam_rst, a_load_ready); end
    tick();
    RST = 1'b0;
    #1;
    total++; if (a_load_ready !== 1'b1 || a_done !== 1'b0 || a_res_min !== 10'd0 || b_timeout !== 1'b0) begin bad++; $display("FAIL rst_back_to_load: got ready=%0d done=%0d min=%0d to=%0d want 1/0/0/0", a_load_ready, a_done, a_res_min, b_timeout); end
    total++; if (a_cost !== 7'd0) begin bad++; $display("FAIL load_cost_zero: got %0d want 0", a_cost); end
  endtask

  task automatic test_toggle();
    int acc = 0;
    for (int c = 0; c < 127; c++) begin
      load_valid = (c % 2 == 0);
      load_data  = 7'((acc * 5 + 3) % 128);
      #1;
      if (load_valid && a_load_ready === 1'b1) begin
        exp_tab[acc] = load_data;
        acc++;
      end
      tick();
    end
    total++; if (acc != 64) begin bad++; $display("FAIL toggle_accepts: got %0d want 64", acc); end
    total++; if (a_load_ready !== 1'b0 || a_jam_rst !== 1'b1) begin bad++; $display("FAIL toggle_release: got ready=%0d jam_rst=%0d want 0/1", a_load_ready, a_jam_rst); end
    // Entries offered after the load completes must not land in the table.
    load_valid = 1'b1; load_data = 7'h7F;
    tick();
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      W = 3'(k / 8); J = 3'(k % 8);
      #1;
      total++; if (a_cost !== exp_tab[k]) begin bad++; $display("FAIL toggle_table[%0d]: got %0d want %0d", k, a_cost, exp_tab[k]); end
    end
  endtask

  task automatic test_rst_midload();
    int acc = 0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      load_data = 7'(100 + i);
      tick();
    end
    RST = 1'b1;
    #1;
    total++; if (a_load_ready !== 1'b0 || a_jam_rst !== 1'b1) begin bad++; $display("FAIL midload_rst: got ready=%0d jam_rst=%0d want 0/1", a_load_ready, a_jam_rst); end
    tick();
    RST = 1'b0;
    load_data = 7'd1;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (a_load_ready === 1'b1) acc++;
      tick();
    end
    load_valid = 1'b0;
    total++; if (acc != 64) begin bad++; $display("FAIL reload_accepts: got %0d want 64", acc); end
    total++; if (a_load_ready !== 1'b0) begin bad++; $display("FAIL reload_release: got %0d want 0", a_load_ready); end
    tick();
    for (int k = 0; k < 64; k++) begin
      W = 3'(k / 8); J = 3'(k % 8);
      #1;
      total++; if (a_cost !== 7'd1) begin bad++; $display("FAIL reload_cost[%0d]: got %0d want 1", k, a_cost); end
    end
  endtask

  initial begin
    test_reset();
    test_load_full();
    test_timeout();
    test_valid_capture();
    test_rst_serve();
    test_toggle();
    test_rst_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
